mips_write_monitor: RTL and testbench
=====================================

Name: mips_write_monitor

Overview:
- Synthesizable store-bus monitor that sits directly downstream of the multicycle MIPS top.
- Consumes the processor's memwrite/dataadr/writedata outputs and logs every store into a small show-ahead FIFO.
- Declares pass when the expected store appears, or fail on a wrong-data store to the target address or on timeout.
- Lets benches and FPGA builds self-check the program without relying on simulator-only $stop.

Parameters:
- TARGET_ADDR, 84, store address that ends the test.
- TARGET_DATA, 7, data required at TARGET_ADDR for pass.
- TIMEOUT_CYCLES, 1000, cycles after reset release before fail; must be ≥2.
- DEPTH, 8, log FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- memwrite  input  1  store strobe from processor top.
- dataadr  input  32  store address from processor top.
- writedata  input  32  store data from processor top.
- rd_en  input  1  pop FIFO head; ignored when rd_valid=0.
- rd_valid  output  1  FIFO not empty.
- rd_addr  output  32  head entry address, valid when rd_valid=1.
- rd_data  output  32  head entry data, valid when rd_valid=1.
- fifo_count  output  log2(DEPTH)+1  entries held.
- overflow  output  1  sticky: a store was dropped because the FIFO was full.
- write_count  output  16  stores seen in RUN, saturating at 16'hFFFF.
- done  output  1  state is PASS or FAIL.
- pass  output  1  state is PASS.
- fail_code  output  2  0=none, 1=timeout, 2=data mismatch at TARGET_ADDR.

Behaviour:
- Reset (async, immediate):
  - state=RUN; FIFO empty; fifo_count=0; rd_valid=0.
  - rd_addr=rd_data=0 (head regs cleared).
  - overflow=0, write_count=0, cycle counter=0.
  - done=0, pass=0, fail_code=0.
- Sampling:
  - A store is memwrite=1 at a rising clk edge in state RUN.
  - memwrite is ignored in PASS/FAIL; no FIFO push and no count change.
- State machine (RUN, PASS, FAIL; PASS and FAIL are terminal until reset):
  - RUN→PASS: store with dataadr==TARGET_ADDR and writedata==TARGET_DATA.
  - RUN→FAIL, fail_code=2: store with dataadr==TARGET_ADDR and writedata!=TARGET_DATA.
  - RUN→FAIL, fail_code=1: cycle counter==TIMEOUT_CYCLES-1 at an edge while in RUN and no store-to-target at that edge.
  - A target store wins over timeout in the same cycle.
  - Outputs are registered: done/pass/fail_code change in the cycle after the deciding edge.
- Cycle counter:
  - Increments each edge in RUN, starting from 0 after reset release.
  - Freezes in terminal states.
- FIFO:
  - Every sampled store pushes {dataadr, writedata}, including the deciding store.
  - Show-ahead: head is visible on rd_addr/rd_data whenever rd_valid=1.
  - rd_en with rd_valid=1 pops at the edge.
  - Push when full with no pop: store dropped, overflow set (sticky until reset), write_count still increments.
  - Push and pop in the same cycle when full: both happen, count stays DEPTH, no overflow.
  - Push and pop in the same cycle when empty: push only; the entry appears next cycle.
  - Pointers wrap modulo DEPTH.
  - Reads continue to work in PASS/FAIL.
- write_count: +1 per sampled store; saturates at 0xFFFF and holds.
- Reset mid-operation: all state returns to reset values immediately; FIFO contents are discarded.

Test Plan:
- Reset held for 2 cycles, then stores (80,5), (84,7) → FIFO holds 2 entries; pass=1 and done=1 the cycle after the (84,7) edge; fail_code=0; write_count=2; subsequent stores not logged.
- Store (84,3) → done=1, pass=0, fail_code=2 next cycle; FIFO head=(84,3).
- No stores, TIMEOUT_CYCLES=16 → fail_code=1 with done rising exactly 16 cycles after reset release. Repeat with (84,7) at cycle index 15 → pass wins.
- DEPTH=8: 10 stores to address 0 with rd_en=0 → fifo_count=8, overflow=1, write_count=10. Then pop 8 → entries 1..8 returned in order, rd_valid=0.
- FIFO full with push and pop in the same cycle → fifo_count stays 8, overflow stays 0, new entry at tail.
- Async reset asserted mid-clock-period during RUN with 3 entries → all outputs 0 before the next edge; fresh run then passes normally.

Source files
------------

// File: rtl/mips_write_monitor.sv
// Store-bus monitor for the multicycle MIPS top.
// Logs every store seen while running into a show-ahead FIFO and decides
// pass/fail from the store to TARGET_ADDR, or fails on a cycle timeout.
module mips_write_monitor #(
    parameter logic [31:0] TARGET_ADDR    = 32'd84,
    parameter logic [31:0] TARGET_DATA    = 32'd7,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned DEPTH          = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [31:0]              dataadr,
    input  logic [31:0]              writedata,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [31:0]              rd_addr,
    output logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [15:0]              write_count,
    output logic                     done,
    output logic                     pass,
    output logic [1:0]               fail_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     fail_code_q, fail_code_d;
    logic [31:0]    cyc_q, cyc_d;
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [15:0]    wcount_q, wcount_d;
    logic [63:0]    mem_q [DEPTH];
    logic [63:0]    mem_d [DEPTH];

    logic store, hit_target, timeout;
    logic pop, push, full;

    // Store qualification and pass/fail decision; the counter only runs while in RUN
    always_comb begin
        store       = memwrite && (state_q == ST_RUN);
        hit_target  = store && (dataadr == TARGET_ADDR);
        timeout     = (cyc_q == 32'(TIMEOUT_CYCLES - 1));
        state_d     = state_q;
        fail_code_d = fail_code_q;
        cyc_d       = cyc_q;
        if (state_q == ST_RUN) begin
            cyc_d = cyc_q + 32'd1;
            if (hit_target) begin
                // A target store takes priority over a simultaneous timeout
                if (writedata == TARGET_DATA) begin
                    state_d = ST_PASS;
                end else begin
                    state_d     = ST_FAIL;
                    fail_code_d = 2'd2;
                end
            end else if (timeout) begin
                state_d     = ST_FAIL;
                fail_code_d = 2'd1;
            end
        end
    end

    // FIFO bookkeeping: a full FIFO still accepts a push when the head pops the same edge
    always_comb begin
        pop        = rd_en && (count_q != '0);
        full       = (count_q == CW'(DEPTH));
        push       = store && (!full || pop);
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (store && full && !pop);
        wcount_d   = wcount_q;
        mem_d      = mem_q;
        if (push) begin
            mem_d[wptr_q] = {dataadr, writedata};
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (store && (wcount_q != 16'hFFFF)) begin
            wcount_d = wcount_q + 16'd1;
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            fail_code_q <= 2'd0;
            cyc_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            wcount_q    <= '0;
        end else begin
            state_q     <= state_d;
            fail_code_q <= fail_code_d;
            cyc_q       <= cyc_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            wcount_q    <= wcount_d;
        end
    end

    // Log storage; contents are meaningless while empty so it needs no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head is forced to zero when empty so reset and drained states read as cleared
    always_comb begin
        rd_valid    = (count_q != '0);
        rd_addr     = rd_valid ? mem_q[rptr_q][63:32] : 32'd0;
        rd_data     = rd_valid ? mem_q[rptr_q][31:0]  : 32'd0;
        fifo_count  = count_q;
        overflow    = overflow_q;
        write_count = wcount_q;
        done        = (state_q != ST_RUN);
        pass        = (state_q == ST_PASS);
        fail_code   = fail_code_q;
    end

endmodule

// File: tb/tb_mips_write_monitor.sv
// Directed bench for mips_write_monitor (DEPTH=8, TIMEOUT_CYCLES=16).
module tb_mips_write_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [15:0] write_count;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;

    int n_cmp = 0;
    int n_err = 0;

    mips_write_monitor #(
        .TARGET_ADDR(32'd84),
        .TARGET_DATA(32'd7),
        .TIMEOUT_CYCLES(16),
        .DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_addr(rd_addr), .rd_data(rd_data), .fifo_count(fifo_count),
        .overflow(overflow), .write_count(write_count), .done(done),
        .pass(pass), .fail_code(fail_code)
    );

    always #5 clk = ~clk;

    // Hold reset over two edges, release 1 time unit after an edge
    task automatic do_reset();
        reset = 1'b1; memwrite = 1'b0; rd_en = 1'b0; dataadr = '0; writedata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One edge with the given bus values; returns 1 unit after the edge
    task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic re);
        memwrite = mw; dataadr = a; writedata = d; rd_en = re;
        @(posedge clk);
        #1;
        memwrite = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({rd_valid, fifo_count, overflow, write_count, done, pass, fail_code} !== 26'd0) begin
            n_err++; $display("FAIL reset_ctrl got %h exp 0", {rd_valid, fifo_count, overflow, write_count, done, pass, fail_code}); end
        n_cmp++; if ({rd_addr, rd_data} !== 64'd0) begin
            n_err++; $display("FAIL reset_head got %h exp 0", {rd_addr, rd_data}); end
    endtask

    task automatic test_pass();
        do_reset();
        cyc(1'b1, 32'd80, 32'd5, 1'b0);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL pass_early_done got %b exp 0", done); end
        cyc(1'b1, 32'd84, 32'd7, 1'b0);
        n_cmp++; if ({done, pass, fail_code} !== 4'b1100) begin
            n_err++; $display("FAIL pass_flags got %b exp 1100", {done, pass, fail_code}); end
        n_cmp++; if (write_count !== 16'd2) begin n_err++; $display("FAIL pass_wcount got %0d exp 2", write_count); end
        n_cmp++; if (fifo_count !== 4'd2) begin n_err++; $display("FAIL pass_count got %0d exp 2", fifo_count); end
        n_cmp++; if ({rd_addr, rd_data} !== {32'd80, 32'd5}) begin
            n_err++; $display("FAIL pass_head got %0d,%0d exp 80,5", rd_addr, rd_data); end
        cyc(1'b1, 32'd90, 32'd1, 1'b0);
        n_cmp++; if ({fifo_count, write_count} !== {4'd2, 16'd2}) begin
            n_err++; $display("FAIL pass_ignore got %0d,%0d exp 2,2", fifo_count, write_count); end
        cyc(1'b0, 32'd0, 32'd0, 1'b1);
        n_cmp++; if ({rd_addr, rd_data} !== {32'd84, 32'd7}) begin
            n_err++; $display("FAIL pass_pop got %0d,%0d exp 84,7", rd_addr, rd_data); end
    endtask

    task automatic test_mismatch();
        do_reset();
        cyc(1'b1, 32'd84, 32'd3, 1'b0);
        n_cmp++; if ({done, pass, fail_code} !== 4'b1010) begin
            n_err++; $display("FAIL mism_flags got %b exp 1010", {done, pass, fail_code}); end
        n_cmp++; if ({rd_valid, rd_addr, rd_data} !== {1'b1, 32'd84, 32'd3}) begin
            n_err++; $display("FAIL mism_head got %b,%0d,%0d exp 1,84,3", rd_valid, rd_addr, rd_data); end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (15) cyc(1'b0, 32'd0, 32'd0, 1'b0);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL tmo_early got %b exp 0", done); end
        cyc(1'b0, 32'd0, 32'd0, 1'b0);
        n_cmp++; if ({done, pass, fail_code} !== 4'b1001) begin
            n_err++; $display("FAIL tmo_flags got %b exp 1001", {done, pass, fail_code}); end
        repeat (3) cyc(1'b0, 32'd0, 32'd0, 1'b0);
        n_cmp++; if (fail_code !== 2'd1) begin n_err++; $display("FAIL tmo_hold got %0d exp 1", fail_code); end
    endtask

    task automatic test_timeout_race();
        do_reset();
        repeat (15) cyc(1'b0, 32'd0, 32'd0, 1'b0);
        cyc(1'b1, 32'd84, 32'd7, 1'b0);
        n_cmp++; if ({done, pass, fail_code} !== 4'b1100) begin
            n_err++; $display("FAIL race_flags got %b exp 1100", {done, pass, fail_code}); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 10; i++) cyc(1'b1, 32'd0, 32'(i), 1'b0);
        n_cmp++; if ({fifo_count, overflow, write_count} !== {4'd8, 1'b1, 16'd10}) begin
            n_err++; $display("FAIL ovf_state got %0d,%b,%0d exp 8,1,10", fifo_count, overflow, write_count); end
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if ({rd_valid, rd_addr, rd_data} !== {1'b1, 32'd0, 32'(i)}) begin
                n_err++; $display("FAIL ovf_pop%0d got %b,%0d,%0d exp 1,0,%0d", i, rd_valid, rd_addr, rd_data, i); end
            cyc(1'b0, 32'd0, 32'd0, 1'b1);
        end
        n_cmp++; if ({rd_valid, fifo_count, overflow} !== {1'b0, 4'd0, 1'b1}) begin
            n_err++; $display("FAIL ovf_drain got %b,%0d,%b exp 0,0,1", rd_valid, fifo_count, overflow); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 11; i <= 18; i++) cyc(1'b1, 32'd4, 32'(i), 1'b0);
        cyc(1'b1, 32'd4, 32'd19, 1'b1);
        n_cmp++; if ({fifo_count, overflow, write_count} !== {4'd8, 1'b0, 16'd9}) begin
            n_err++; $display("FAIL b2b_state got %0d,%b,%0d exp 8,0,9", fifo_count, overflow, write_count); end
        for (int i = 12; i <= 19; i++) begin
            n_cmp++; if (rd_data !== 32'(i)) begin
                n_err++; $display("FAIL b2b_pop got %0d exp %0d", rd_data, i); end
            cyc(1'b0, 32'd0, 32'd0, 1'b1);
        end
        // Push and pop on an empty FIFO: only the push takes effect
        do_reset();
        cyc(1'b1, 32'd8, 32'd9, 1'b1);
        n_cmp++; if ({rd_valid, fifo_count, rd_addr, rd_data} !== {1'b1, 4'd1, 32'd8, 32'd9}) begin
            n_err++; $display("FAIL empty_pp got %b,%0d,%0d,%0d exp 1,1,8,9", rd_valid, fifo_count, rd_addr, rd_data); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 3; i++) cyc(1'b1, 32'(i), 32'(i), 1'b0);
        n_cmp++; if (fifo_count !== 4'd3) begin n_err++; $display("FAIL ar_pre got %0d exp 3", fifo_count); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({rd_valid, fifo_count, write_count, rd_addr, rd_data, done} !== 86'd0) begin
            n_err++; $display("FAIL ar_clear got %b,%0d,%0d,%0d,%0d,%b exp all 0", rd_valid, fifo_count, write_count, rd_addr, rd_data, done); end
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1'b1, 32'd84, 32'd7, 1'b0);
        n_cmp++; if ({done, pass, fail_code, fifo_count, write_count} !== {4'b1100, 4'd1, 16'd1}) begin
            n_err++; $display("FAIL ar_rerun got %b,%0d,%0d exp 1100,1,1", {done, pass, fail_code}, fifo_count, write_count); end
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; rd_en = 1'b0; dataadr = '0; writedata = '0;
        test_reset();
        test_pass();
        test_mismatch();
        test_timeout();
        test_timeout_race();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
